// File: rtl/spi_frame_engine.sv
// SPI slave frame engine: decodes 16-bit command/data frames into register strobes and serializes read data.
// Optional aborted-frame counter is built when SPI_FRAME_ERR_EN is defined.
module spi_frame_engine #(
    parameter int ADDR_WIDTH = 6,
    parameter int REG_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [1:0]            mode,
    input  logic                  spi_cs_n,
    input  logic                  spi_clk,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [REG_WIDTH-1:0]  rd_data,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [REG_WIDTH-1:0]  wr_data,
    output logic [7:0]            err_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        LOAD,
        DATA,
        DONE
    } state_t;

    localparam int CNT_MAX = (REG_WIDTH > 8) ? REG_WIDTH : 8;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(7);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(REG_WIDTH - 1);

    state_t                state;
    state_t                state_next;
    logic                  sclk_d;
    logic [1:0]            mode_q;
    logic [CNT_W-1:0]      bit_cnt;
    logic [7:0]            cmd_sr;
    logic [REG_WIDTH-1:0]  tx_sr;
    logic [REG_WIDTH-1:0]  rx_sr;
    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [REG_WIDTH-1:0]  wr_data_q;

    logic                  rise;
    logic                  fall;
    logic                  sample_edge;
    logic                  shift_edge;
    logic [7:0]            cmd_next;
    logic [REG_WIDTH-1:0]  rx_next;

    logic                  start;
    logic                  sample_cmd;
    logic                  cmd_done;
    logic                  load_tx;
    logic                  sample_data;
    logic                  data_done;
    logic                  shift_tx;

    // Modes 1 and 2 sample on the falling SCLK edge, modes 0 and 3 on the rising edge.
    assign rise        = spi_clk & ~sclk_d;
    assign fall        = ~spi_clk & sclk_d;
    assign sample_edge = (mode_q[1] ^ mode_q[0]) ? fall : rise;
    assign shift_edge  = (mode_q[1] ^ mode_q[0]) ? rise : fall;

    assign cmd_next = 8'({cmd_sr, spi_mosi});
    assign rx_next  = REG_WIDTH'({rx_sr, spi_mosi});

    assign spi_miso = (state == DATA) ? tx_sr[REG_WIDTH-1] : 1'b0;
    assign wr_en    = wr_en_q & ena;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        start       = 1'b0;
        sample_cmd  = 1'b0;
        cmd_done    = 1'b0;
        load_tx     = 1'b0;
        sample_data = 1'b0;
        data_done   = 1'b0;
        shift_tx    = 1'b0;
        if (ena) begin
            case (state)
                IDLE: begin
                    if (!spi_cs_n) begin
                        start      = 1'b1;
                        state_next = CMD;
                    end
                end
                CMD: begin
                    if (spi_cs_n) begin
                        state_next = IDLE;
                    end else if (sample_edge) begin
                        sample_cmd = 1'b1;
                        if (bit_cnt == CMD_LAST) begin
                            cmd_done   = 1'b1;
                            state_next = LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (spi_cs_n) begin
                        state_next = IDLE;
                    end else begin
                        load_tx    = 1'b1;
                        state_next = DATA;
                    end
                end
                DATA: begin
                    // The first shift edge of the phase is skipped so the MSB stays up for the first sample.
                    if (spi_cs_n) begin
                        state_next = IDLE;
                    end else if (sample_edge) begin
                        sample_data = 1'b1;
                        if (bit_cnt == DATA_LAST) begin
                            data_done  = 1'b1;
                            state_next = DONE;
                        end
                    end else if (shift_edge && (bit_cnt != '0)) begin
                        shift_tx = 1'b1;
                    end
                end
                DONE: begin
                    if (spi_cs_n) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_d    <= 1'b0;
            mode_q    <= 2'b00;
            bit_cnt   <= '0;
            cmd_sr    <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            rd_addr   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else if (ena) begin
            sclk_d  <= spi_clk;
            wr_en_q <= 1'b0;
            if (start) begin
                mode_q  <= mode;
                bit_cnt <= '0;
            end
            if (sample_cmd) begin
                cmd_sr  <= cmd_next;
                bit_cnt <= cmd_done ? '0 : bit_cnt + 1'b1;
            end
            if (cmd_done) begin
                rd_addr <= cmd_next[ADDR_WIDTH-1:0];
            end
            if (load_tx) begin
                tx_sr <= rd_data;
            end
            if (shift_tx) begin
                tx_sr <= tx_sr << 1;
            end
            if (sample_data) begin
                rx_sr   <= rx_next;
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (data_done && cmd_sr[7]) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= cmd_sr[ADDR_WIDTH-1:0];
                wr_data_q <= rx_next;
            end
        end else begin
            wr_en_q <= 1'b0;
        end
    end

`ifdef SPI_FRAME_ERR_EN
    logic       abort;
    logic [7:0] err_cnt_q;

    // A frame counts as aborted only if chip select rises before the data phase completes.
    assign abort   = ena & spi_cs_n & ((state == CMD) | (state == LOAD) | (state == DATA));
    assign err_cnt = err_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= 8'h00;
        end else if (abort && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'h01;
        end
    end
`else
    assign err_cnt = 8'h00;
`endif

endmodule
